// File: rtl/add_pkg.sv
// add_pkg
//  Shared definitions for the FP64 pre-add alignment stage.
//  - state_t    : alignment FSM encoding (IDLE -> CMP -> SHIFT* -> NEG)
//  - EXP_W      : exponent width
//  - MAN_W      : stored significand width
//  - HID_W      : significand width including the hidden bit
//  - DSHIFT_MAX : largest useful alignment distance; any larger shift clears the significand
//  - D_W        : width of the remaining-shift counter
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMP   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_NEG   = 2'd3
    } state_t;

    localparam int EXP_W      = 11;
    localparam int MAN_W      = 52;
    localparam int HID_W      = MAN_W + 1;
    localparam int DSHIFT_MAX = 53;
    localparam int D_W        = $clog2(DSHIFT_MAX + 1);

endpackage

// File: rtl/add_align_shifter.sv
// add_align_shifter
//  Combinational right shifter that moves a significand by at most STEP bits.
//  The actual distance is min(rem_in, STEP).
//  Ports:
//   m_in    [W]  significand to shift
//   rem_in  [RW] shift distance still outstanding
//   m_out   [W]  shifted significand
//   rem_out [RW] distance still outstanding after this step
//   lost    [1]  OR of every bit shifted out in this step
module add_align_shifter #(
    parameter int STEP = 16,
    parameter int W    = 53,
    parameter int RW   = 6
) (
    input  logic [W-1:0]  m_in,
    input  logic [RW-1:0] rem_in,
    output logic [W-1:0]  m_out,
    output logic [RW-1:0] rem_out,
    output logic          lost
);

    logic [RW-1:0] step;
    logic [W-1:0]  lost_bits;

    always_comb begin
        step    = (rem_in > RW'(STEP)) ? RW'(STEP) : rem_in;
        m_out   = m_in >> step;
        rem_out = rem_in - step;
    end

    // Bit gi falls off the bottom exactly when it sits below the shift distance.
    genvar gi;
    for (gi = 0; gi < W; gi++) begin : g_lost
        assign lost_bits[gi] = m_in[gi] & (gi < int'(step));
    end

    assign lost = |lost_bits;

endmodule

// File: rtl/add_align.sv
// add_align
//  FP64 pre-add alignment stage. Orders two doubles by magnitude, right-aligns
//  the smaller significand over several SHIFT cycles (SHIFT_STEP bits max per
//  cycle) and two's-complements it when the effective signs differ.
//  Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   a, b, sub       operands; sub=1 computes a-b (sign of b flipped on capture)
//   busy            high from the cycle after an accepted start through the valid cycle
//   valid           one-cycle pulse; results hold until the next result is produced
//   op1             larger-magnitude operand, untouched
//   op2             {effective sign, exponent, aligned/negated significand} of the smaller
//   exp_same        exponents of a and b equal
//   sign_same       sign(a) == effective sign(b)
//   sticky          OR of all significand bits shifted out of op2
module add_align #(
    parameter int SHIFT_STEP = 16,
    parameter int EXP_W      = add_pkg::EXP_W,
    parameter int MAN_W      = add_pkg::MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     busy,
    output logic                     valid,
    output logic [EXP_W+MAN_W:0]     op1,
    output logic [EXP_W+MAN_W:0]     op2,
    output logic                     exp_same,
    output logic                     sign_same,
    output logic                     sticky
);

    import add_pkg::*;

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MAG_W = EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    // Hold {a, effective b} between IDLE and CMP, then {larger, smaller}.
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       y_q, y_d;
    logic [SIG_W-1:0]   m_q, m_d;
    logic [D_W-1:0]     rem_q, rem_d;
    logic               acc_sticky_q, acc_sticky_d;
    logic               eq_exp_q, eq_exp_d;
    logic               eq_sign_q, eq_sign_d;
    logic [W-1:0]       op1_q, op1_d;
    logic [W-1:0]       op2_q, op2_d;
    logic               exp_same_q, exp_same_d;
    logic               sign_same_q, sign_same_d;
    logic               sticky_q, sticky_d;

    logic [SIG_W-1:0]   sh_m;
    logic [D_W-1:0]     sh_rem;
    logic               sh_lost;

    add_align_shifter #(
        .STEP (SHIFT_STEP),
        .W    (SIG_W),
        .RW   (D_W)
    ) u_shifter (
        .m_in    (m_q),
        .rem_in  (rem_q),
        .m_out   (sh_m),
        .rem_out (sh_rem),
        .lost    (sh_lost)
    );

    logic               a_ge;
    logic [W-1:0]       cmp_big;
    logic [W-1:0]       cmp_sml;
    logic [EXP_W-1:0]   exp_diff;
    logic [D_W-1:0]     d_clamp;
    logic [MAN_W-1:0]   neg_sig;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        m_d          = m_q;
        rem_d        = rem_q;
        acc_sticky_d = acc_sticky_q;
        eq_exp_d     = eq_exp_q;
        eq_sign_d    = eq_sign_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        exp_same_d   = exp_same_q;
        sign_same_d  = sign_same_q;
        sticky_d     = sticky_q;

        // Magnitude compare on {exp, man}; a wins ties.
        a_ge     = x_q[MAG_W-1:0] >= y_q[MAG_W-1:0];
        cmp_big  = a_ge ? x_q : y_q;
        cmp_sml  = a_ge ? y_q : x_q;
        exp_diff = cmp_big[MAG_W-1:MAN_W] - cmp_sml[MAG_W-1:MAN_W];
        d_clamp  = (exp_diff > EXP_W'(DSHIFT_MAX)) ? D_W'(DSHIFT_MAX)
                                                    : exp_diff[D_W-1:0];
        neg_sig  = eq_sign_q ? m_q[MAN_W-1:0] : -m_q[MAN_W-1:0];

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Subtraction is folded into b's sign here, so sub is not kept.
                    x_d     = a;
                    y_d     = {b[W-1] ^ sub, b[W-2:0]};
                    busy_d  = 1'b1;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                eq_exp_d     = x_q[MAG_W-1:MAN_W] == y_q[MAG_W-1:MAN_W];
                eq_sign_d    = x_q[W-1] == y_q[W-1];
                x_d          = cmp_big;
                y_d          = cmp_sml;
                acc_sticky_d = 1'b0;
                rem_d        = d_clamp;
                if (d_clamp == '0) begin
                    // Equal exponents: the adder supplies both hidden bits itself.
                    m_d     = {1'b0, cmp_sml[MAN_W-1:0]};
                    state_d = ST_NEG;
                end else begin
                    m_d     = {(cmp_sml[MAG_W-1:MAN_W] != '0), cmp_sml[MAN_W-1:0]};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                m_d          = sh_m;
                rem_d        = sh_rem;
                acc_sticky_d = acc_sticky_q | sh_lost;
                if (sh_rem == '0) begin
                    state_d = ST_NEG;
                end
            end
            ST_NEG: begin
                op1_d       = x_q;
                op2_d       = {y_q[W-1], y_q[MAG_W-1:MAN_W], neg_sig};
                exp_same_d  = eq_exp_q;
                sign_same_d = eq_sign_q;
                sticky_d    = acc_sticky_q;
                valid_d     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            m_q          <= '0;
            rem_q        <= '0;
            acc_sticky_q <= 1'b0;
            eq_exp_q     <= 1'b0;
            eq_sign_q    <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            exp_same_q   <= 1'b0;
            sign_same_q  <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            m_q          <= m_d;
            rem_q        <= rem_d;
            acc_sticky_q <= acc_sticky_d;
            eq_exp_q     <= eq_exp_d;
            eq_sign_q    <= eq_sign_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            exp_same_q   <= exp_same_d;
            sign_same_q  <= sign_same_d;
            sticky_q     <= sticky_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign exp_same  = exp_same_q;
    assign sign_same = sign_same_q;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_add_align.sv
// tb_add_align
//  Directed bench for add_align: each task drives one scenario and checks
//  latency (cycles from the start cycle to the valid cycle) and the results.
module tb_add_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy, valid, exp_same, sign_same, sticky;
    logic [63:0] op1, op2;

    int errors = 0;
    int checks = 0;

    add_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .busy      (busy),
        .valid     (valid),
        .op1       (op1),
        .op2       (op2),
        .exp_same  (exp_same),
        .sign_same (sign_same),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    // Drives one request in cycle 0 and waits (bounded) for valid.
    // lat = cycle index of the valid cycle, or -1 if it never came.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_in,
                         input logic ts, output int lat);
        @(posedge clk); #1;
        a = ta; b = tb_in; sub = ts; start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) begin
                lat = c;
                break;
            end
        end
        $display("op a=%016h b=%016h sub=%0d lat=%0d op1=%016h op2=%016h es=%0d ss=%0d st=%0d",
                 ta, tb_in, ts, lat, op1, op2, exp_same, sign_same, sticky);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (op1 !== 64'h0 || op2 !== 64'h0) begin errors++; $display("FAIL reset_ops got %016h/%016h want 0/0", op1, op2); end
        checks++; if ({exp_same, sign_same, sticky} !== 3'b000) begin errors++; $display("FAIL reset_flags got %03b want 000", {exp_same, sign_same, sticky}); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_equal();
        int lat;
        do_op(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL eq_latency got %0d want 3", lat); end
        checks++; if (op1 !== 64'h3FF0000000000000) begin errors++; $display("FAIL eq_op1 got %016h want 3ff0000000000000", op1); end
        checks++; if (op2 !== 64'h3FF0000000000000) begin errors++; $display("FAIL eq_op2 got %016h want 3ff0000000000000", op2); end
        checks++; if ({exp_same, sign_same, sticky} !== 3'b110) begin errors++; $display("FAIL eq_flags got %03b want 110", {exp_same, sign_same, sticky}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL eq_busy_at_valid got %0b want 1", busy); end
    endtask

    task automatic test_shift_one();
        int lat;
        do_op(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sh1_latency got %0d want 4", lat); end
        checks++; if (op2 !== 64'h3FE8000000000000) begin errors++; $display("FAIL sh1_op2 got %016h want 3fe8000000000000", op2); end
        checks++; if ({exp_same, sign_same, sticky} !== 3'b010) begin errors++; $display("FAIL sh1_flags got %03b want 010", {exp_same, sign_same, sticky}); end
        // Results must hold for the downstream adder's four cycles.
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sh1_idle_%0d got v=%0b b=%0b want 0/0", k, valid, busy); end
            checks++; if (op1 !== 64'h3FF0000000000000 || op2 !== 64'h3FE8000000000000) begin errors++; $display("FAIL sh1_hold_%0d got %016h/%016h", k, op1, op2); end
        end
    endtask

    task automatic test_swap();
        int lat;
        do_op(64'h3FE0000000000000, 64'h4000000000000000, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL swap_latency got %0d want 4", lat); end
        checks++; if (op1 !== 64'h4000000000000000) begin errors++; $display("FAIL swap_op1 got %016h want 4000000000000000", op1); end
        checks++; if (op2 !== 64'h3FE4000000000000) begin errors++; $display("FAIL swap_op2 got %016h want 3fe4000000000000", op2); end
    endtask

    task automatic test_sub();
        int lat;
        do_op(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got %0d want 4", lat); end
        checks++; if (op1 !== 64'h3FF0000000000000) begin errors++; $display("FAIL sub_op1 got %016h want 3ff0000000000000", op1); end
        checks++; if (op2 !== 64'hBFE8000000000000) begin errors++; $display("FAIL sub_op2 got %016h want bfe8000000000000", op2); end
        checks++; if (sign_same !== 1'b0) begin errors++; $display("FAIL sub_sign_same got %0b want 0", sign_same); end
    endtask

    task automatic test_multi_step();
        int lat;
        // d=17: a 16-bit step then a 1-bit step; bit 0 of M is lost.
        do_op(64'h4100000000000000, 64'h3FF0000000000001, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL ms_latency got %0d want 5", lat); end
        checks++; if (op2 !== 64'h3FF0000800000000) begin errors++; $display("FAIL ms_op2 got %016h want 3ff0000800000000", op2); end
        checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL ms_sticky got %0b want 1", sticky); end
    endtask

    task automatic test_clamp();
        int lat;
        do_op(64'h43C0000000000000, 64'h3FF0000000000001, 1'b0, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL clamp_latency got %0d want 7", lat); end
        checks++; if (op1 !== 64'h43C0000000000000) begin errors++; $display("FAIL clamp_op1 got %016h want 43c0000000000000", op1); end
        checks++; if (op2 !== 64'h3FF0000000000000) begin errors++; $display("FAIL clamp_op2 got %016h want 3ff0000000000000", op2); end
        checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL clamp_sticky got %0b want 1", sticky); end
    endtask

    task automatic test_zero();
        int lat;
        // Zero smaller operand under subtraction: negating zero must stay zero.
        do_op(64'h3FF0000000000000, 64'h0000000000000000, 1'b1, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL zero_latency got %0d want 7", lat); end
        checks++; if (op2 !== 64'h8000000000000000) begin errors++; $display("FAIL zero_op2 got %016h want 8000000000000000", op2); end
        checks++; if ({exp_same, sign_same, sticky} !== 3'b000) begin errors++; $display("FAIL zero_flags got %03b want 000", {exp_same, sign_same, sticky}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        a = 64'h3FF0000000000000; b = 64'h3FE0000000000000; sub = 1'b0; start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_c1 got %0b want 1", busy); end
            end
            // Competing request while busy: must be ignored.
            if (c == 2) begin
                a = 64'h4000000000000000; b = 64'h3FE0000000000000; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                lat = c;
                break;
            end
        end
        $display("op b2b lat=%0d op1=%016h op2=%016h", lat, op1, op2);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
        checks++; if (op1 !== 64'h3FF0000000000000 || op2 !== 64'h3FE8000000000000) begin errors++; $display("FAIL b2b_result got %016h/%016h want 3ff0000000000000/3fe8000000000000", op1, op2); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL b2b_after got busy=%0b valid=%0b want 0/0", busy, valid); end
        do_op(64'h3FE0000000000000, 64'h4000000000000000, 1'b0, lat);
        checks++; if (lat !== 4 || op2 !== 64'h3FE4000000000000) begin errors++; $display("FAIL b2b_next got lat=%0d op2=%016h want 4/3fe4000000000000", lat, op2); end
    endtask

    task automatic test_abort();
        int lat;
        @(posedge clk); #1;
        a = 64'h43C0000000000000; b = 64'h3FF0000000000001; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_ctl got busy=%0b valid=%0b want 0/0", busy, valid); end
        checks++; if (op1 !== 64'h0 || op2 !== 64'h0) begin errors++; $display("FAIL abort_ops got %016h/%016h want 0/0", op1, op2); end
        checks++; if ({exp_same, sign_same, sticky} !== 3'b000) begin errors++; $display("FAIL abort_flags got %03b want 000", {exp_same, sign_same, sticky}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("abort reset released");
        do_op(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b1, lat);
        checks++; if (lat !== 4 || op2 !== 64'hBFE8000000000000) begin errors++; $display("FAIL abort_next got lat=%0d op2=%016h want 4/bfe8000000000000", lat, op2); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_shift_one();
        test_swap();
        test_sub();
        test_multi_step();
        test_clamp();
        test_zero();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
